// File: rtl/ascii_number_parser.sv
// ASCII line parser: turns a typed fixed-point decimal line ("123.45" CR)
// into a 48-bit packed-BCD word (6 integer digits, 6 fraction digits).
module ascii_number_parser (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [47:0] data_in,
    output logic        data_valid,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {S_INT, S_FRAC, S_ERR} state_t;

    state_t      state_q, state_d;
    logic [23:0] int_q, int_d, frac_q, frac_d;
    logic [2:0]  int_cnt_q, int_cnt_d, frac_cnt_q, frac_cnt_d;
    logic [47:0] data_q, data_d;
    logic        dv_q, dv_d, err_q, err_d, busy_q, busy_d;
    logic        do_commit;

    logic       is_digit, is_dot, is_cr;
    logic [3:0] nib;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_dot   = (rx_data == 8'h2E);
    assign is_cr    = (rx_data == 8'h0D);
    assign nib      = rx_data[3:0];

    always_comb begin
        state_d    = state_q;
        int_d      = int_q;
        frac_d     = frac_q;
        int_cnt_d  = int_cnt_q;
        frac_cnt_d = frac_cnt_q;
        data_d     = data_q;
        dv_d       = 1'b0;
        err_d      = 1'b0;
        do_commit  = 1'b0;

        if (rx_valid) begin
            unique case (state_q)
                S_INT: begin
                    if (is_digit) begin
                        if (int_cnt_q == 3'd6) begin
                            state_d = S_ERR;
                        end else begin
                            int_d     = {int_q[19:0], nib};
                            int_cnt_d = int_cnt_q + 3'd1;
                        end
                    end else if (is_dot) begin
                        state_d = S_FRAC;
                    end else if (is_cr) begin
                        // A CR on an empty line is ignored entirely
                        do_commit = (int_cnt_q != 3'd0);
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_FRAC: begin
                    if (is_digit) begin
                        if (frac_cnt_q == 3'd6) begin
                            state_d = S_ERR;
                        end else begin
                            for (int unsigned i = 0; i < 6; i++) begin
                                if (frac_cnt_q == 3'(i)) frac_d[23-4*i -: 4] = nib;
                            end
                            frac_cnt_d = frac_cnt_q + 3'd1;
                        end
                    end else if (is_cr) begin
                        do_commit = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_ERR: begin
                    if (is_cr) err_d = 1'b1;
                end
                default: state_d = S_INT;
            endcase
        end

        if (do_commit) begin
            data_d = {int_q, frac_q};
            dv_d   = 1'b1;
        end

        if (do_commit || err_d) begin
            state_d    = S_INT;
            int_d      = '0;
            frac_d     = '0;
            int_cnt_d  = '0;
            frac_cnt_d = '0;
        end

        busy_d = (state_d != S_INT) || (int_cnt_d != 3'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_INT;
            int_q      <= '0;
            frac_q     <= '0;
            int_cnt_q  <= '0;
            frac_cnt_q <= '0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            int_q      <= int_d;
            frac_q     <= frac_d;
            int_cnt_q  <= int_cnt_d;
            frac_cnt_q <= frac_cnt_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign data_in    = data_q;
    assign data_valid = dv_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ascii_number_parser.sv
// Directed and random line stimulus for ascii_number_parser, checked
// against a string-level parsing model.
module tb_ascii_number_parser;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [47:0] data_in;
    logic        data_valid;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [47:0] exp_data = '0;

    localparam byte CR = 8'h0D;

    ascii_number_parser dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .data_in    (data_in),
        .data_valid (data_valid),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: parse the whole line text at once.
    task automatic model(input string s, output bit empty, output bit ok, output logic [47:0] v);
        int dots = 0;
        int dpos = -1;
        int ilen, flen;
        logic [47:0] iv = '0;
        logic [47:0] fv = '0;
        empty = (s.len() == 0);
        ok    = 1'b1;
        v     = '0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == ".") begin
                dots++;
                if (dpos < 0) dpos = i;
            end else if (s[i] < "0" || s[i] > "9") begin
                ok = 1'b0;
            end
        end
        if (dots > 1) ok = 1'b0;
        ilen = (dpos < 0) ? s.len() : dpos;
        flen = (dpos < 0) ? 0 : s.len() - dpos - 1;
        if (ilen > 6 || flen > 6) ok = 1'b0;
        if (ok && !empty) begin
            for (int i = 0; i < ilen; i++) iv = iv * 16 + 48'(s[i] - "0");
            for (int j = 0; j < 6; j++) begin
                fv = fv * 16;
                if (j < flen) fv = fv + 48'(s[dpos + 1 + j] - "0");
            end
            v = (iv << 24) | fv;
        end
    endtask

    task automatic put(input byte c);
        @(negedge clk);
        rx_data  = c;
        rx_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = $urandom_range(0, 255);
        end
    endtask

    task automatic send_body(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            put(s[i]);
            if (gap > 0) idle($urandom_range(0, gap));
        end
    endtask

    // Called one cycle after the CR was presented.
    task automatic check_now(input string s);
        bit empty, ok;
        logic [47:0] v;
        model(s, empty, ok, v);
        if (empty) begin
            chk({"dv_empty:", s}, 48'(data_valid), 48'd0);
            chk({"err_empty:", s}, 48'(err), 48'd0);
        end else if (ok) begin
            exp_data = v;
            chk({"dv:", s}, 48'(data_valid), 48'd1);
            chk({"err_ok:", s}, 48'(err), 48'd0);
        end else begin
            chk({"err:", s}, 48'(err), 48'd1);
            chk({"dv_bad:", s}, 48'(data_valid), 48'd0);
        end
        chk({"data:", s}, data_in, exp_data);
    endtask

    task automatic check_quiet(input string tag);
        chk({"dv_pulse_end:", tag}, 48'(data_valid), 48'd0);
        chk({"err_pulse_end:", tag}, 48'(err), 48'd0);
    endtask

    task automatic run_line(input string s, input int gap);
        send_body(s, gap);
        put(CR);
        idle(1);
        check_now(s);
        chk({"busy_after:", s}, 48'(busy), 48'd0);
        idle(1);
        check_quiet(s);
    endtask

    string alpha = "0123456789.a- ";
    string rs;
    int    len, k;

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        chk("reset_data", data_in, 48'd0);
        chk("reset_dv", 48'(data_valid), 48'd0);
        chk("reset_err", 48'(err), 48'd0);
        chk("reset_busy", 48'(busy), 48'd0);
        @(negedge clk);
        reset = 1'b0;

        run_line("123.45", 0);
        chk("123.45_value", data_in, 48'h000123_450000);

        // back-to-back: next line starts in the cycle right after CR
        send_body("999999.999999", 0);
        put(CR);
        put("7");
        check_now("999999.999999");
        chk("max_value", data_in, 48'h999999_999999);
        put(CR);
        idle(1);
        check_now("7");
        chk("b2b_value", data_in, 48'h000007_000000);
        idle(1);
        check_quiet("b2b");

        run_line("1234567", 0);
        run_line("1.2.3", 0);
        run_line("1a", 0);
        chk("err_keeps_data", data_in, 48'h000007_000000);

        put(CR);
        chk("lone_cr_busy_pre", 48'(busy), 48'd0);
        idle(1);
        check_now("");
        chk("lone_cr_busy", 48'(busy), 48'd0);
        idle(1);
        check_quiet("lone_cr");

        run_line(".", 0);
        chk("dot_value", data_in, 48'd0);
        run_line(".5", 0);
        chk("dot5_value", data_in, 48'h000000_500000);

        send_body("12", 0);
        idle(1);
        reset = 1'b1;
        #1;
        chk("midreset_data", data_in, 48'd0);
        chk("midreset_dv", 48'(data_valid), 48'd0);
        chk("midreset_err", 48'(err), 48'd0);
        chk("midreset_busy", 48'(busy), 48'd0);
        idle(1);
        reset = 1'b0;
        exp_data = '0;
        run_line("3", 0);
        chk("midreset_value", data_in, 48'h000003_000000);

        put("4");
        chk("gap_busy_pre", 48'(busy), 48'd0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("gap_busy_a", 48'(busy), 48'd1);
        end
        put(".");
        chk("gap_busy_dot", 48'(busy), 48'd1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("gap_busy_b", 48'(busy), 48'd1);
        end
        put("2");
        chk("gap_busy_2", 48'(busy), 48'd1);
        put(CR);
        chk("gap_busy_cr", 48'(busy), 48'd1);
        idle(1);
        check_now("4.2");
        chk("gap_value", data_in, 48'h000004_200000);
        chk("gap_busy_after", 48'(busy), 48'd0);

        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(0, 9);
            rs  = "";
            for (int i = 0; i < len; i++) begin
                k = ($urandom_range(0, 99) < 80) ? $urandom_range(0, 9) : $urandom_range(10, 13);
                rs = {rs, alpha.substr(k, k)};
            end
            run_line(rs, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
